// File: rtl/flash_copy_pkg.sv
// Shared definitions for the flash-to-blockram copy engine: FSM states,
// configuration register selects and the flash wait timeout length.
package flash_copy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] SEL_SRC  = 2'd0;
  localparam logic [1:0] SEL_DST  = 2'd1;
  localparam logic [1:0] SEL_LEN  = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;

  localparam int TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/flash_copy_if.sv
// Bundles the copy engine's register, status, flash-reader, CPU-store and
// blockram write-port signals; the engine is the slave side.
interface flash_copy_if #(
  parameter int RAM_AW = 9
);
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [31:0]       cfg_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              flash_req;
  logic [21:0]       flash_addr;
  logic              flash_busy;
  logic [31:0]       flash_rdata;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [RAM_AW-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  modport master (
    output cfg_we, cfg_sel, cfg_wdata, flash_busy, flash_rdata,
           cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  busy, done, error, flash_req, flash_addr,
           ram_we, ram_be, ram_addr, ram_wdata
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_wdata, flash_busy, flash_rdata,
           cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output busy, done, error, flash_req, flash_addr,
           ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_port_mux.sv
// CPU-priority 2:1 mux for the blockram write port. The CPU always wins;
// o_grant tells the copy engine its write was accepted this cycle.
module ram_port_mux #(
  parameter int AW = 9
) (
  input  logic          i_cpu_we,
  input  logic [3:0]    i_cpu_be,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  input  logic          i_eng_we,
  input  logic [AW-1:0] i_eng_addr,
  input  logic [31:0]   i_eng_wdata,
  output logic          o_ram_we,
  output logic [3:0]    o_ram_be,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_wdata,
  output logic          o_grant
);

  // Idle port still mirrors the CPU bus so only ram_we distinguishes a write.
  always_comb begin
    o_ram_we    = i_cpu_we;
    o_ram_be    = i_cpu_be;
    o_ram_addr  = i_cpu_addr;
    o_ram_wdata = i_cpu_wdata;
    if (!i_cpu_we && i_eng_we) begin
      o_ram_we    = 1'b1;
      o_ram_be    = 4'hF;
      o_ram_addr  = i_eng_addr;
      o_ram_wdata = i_eng_wdata;
    end
  end

  assign o_grant = !i_cpu_we;

endmodule

// File: rtl/flash_copy_ctrl.sv
// Copies LEN words from the SPI flash reader into blockram, yielding the RAM
// port to CPU stores. Define FLASH_COPY_TIMEOUT_EN to bound the flash wait.
module flash_copy_ctrl
  import flash_copy_pkg::*;
#(
  parameter int RAM_AW = 9,
  parameter int LEN_W  = 8
) (
  input logic         clk,
  input logic         reset,
  flash_copy_if.slave io_bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [21:0]        r_src;
  logic [RAM_AW-1:0]  r_dst;
  logic [LEN_W-1:0]   r_len;
  logic               r_done;
  logic               r_seen_busy;
  logic [31:0]        r_word;

  logic               w_grant;
  logic               w_busy;
  logic               w_flash_req;
  logic               w_eng_we;
  logic               w_cfg_idle;
  logic               w_start;
  logic               w_fetch_done;
  logic               w_word_done;
  logic               w_last;
  logic               w_timeout;
  logic [LEN_W-1:0]   w_len_dec;

  assign w_cfg_idle   = io_bus.cfg_we && (r_state == ST_IDLE);
  assign w_start      = w_cfg_idle && (io_bus.cfg_sel == SEL_CTRL) && io_bus.cfg_wdata[0];
  assign w_fetch_done = (r_state == ST_WAIT) && r_seen_busy && !io_bus.flash_busy;
  assign w_word_done  = (r_state == ST_WRITE) && w_grant;
  assign w_len_dec    = r_len - LEN_W'(1);
  assign w_last       = (w_len_dec == '0);

`ifdef FLASH_COPY_TIMEOUT_EN
  logic [9:0] r_tmo_cnt;
  logic       r_error;

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_WAIT)) r_tmo_cnt <= '0;
    else                               r_tmo_cnt <= r_tmo_cnt + 10'd1;
  end

  // Fires on the last of TIMEOUT_CYCLES wait cycles unless the word arrives then.
  assign w_timeout = (r_state == ST_WAIT) && !w_fetch_done &&
                     (r_tmo_cnt == 10'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)          r_error <= 1'b0;
    else if (w_start)   r_error <= 1'b0;
    else if (w_timeout) r_error <= 1'b1;
  end

  assign io_bus.error = r_error;
`else
  assign w_timeout    = 1'b0;
  assign io_bus.error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_flash_req = 1'b0;
    w_eng_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_start && (r_len != '0)) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_flash_req = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_fetch_done)   w_state_nxt = ST_WRITE;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        w_eng_we = 1'b1;
        if (w_grant) w_state_nxt = w_last ? ST_IDLE : ST_ISSUE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Register file, flash handshake tracking and per-word address advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_done      <= 1'b0;
      r_seen_busy <= 1'b0;
      r_word      <= '0;
    end else begin
      if (w_cfg_idle) begin
        case (io_bus.cfg_sel)
          SEL_SRC: r_src <= io_bus.cfg_wdata[21:0];
          SEL_DST: r_dst <= io_bus.cfg_wdata[RAM_AW-1:0];
          SEL_LEN: r_len <= io_bus.cfg_wdata[LEN_W-1:0];
          default: if (io_bus.cfg_wdata[0]) r_done <= (r_len == '0);
        endcase
      end
      if (r_state == ST_ISSUE)                           r_seen_busy <= 1'b0;
      else if ((r_state == ST_WAIT) && io_bus.flash_busy) r_seen_busy <= 1'b1;
      if (w_fetch_done) r_word <= io_bus.flash_rdata;
      if (w_word_done) begin
        r_src <= r_src + 22'd4;
        r_dst <= r_dst + RAM_AW'(4);
        r_len <= w_len_dec;
        if (w_last) r_done <= 1'b1;
      end
      if (w_timeout) r_done <= 1'b0;
    end
  end

  ram_port_mux #(
    .AW(RAM_AW)
  ) u_ram_port_mux (
    .i_cpu_we   (io_bus.cpu_we),
    .i_cpu_be   (io_bus.cpu_be),
    .i_cpu_addr (io_bus.cpu_addr),
    .i_cpu_wdata(io_bus.cpu_wdata),
    .i_eng_we   (w_eng_we),
    .i_eng_addr ({r_dst[RAM_AW-1:2], 2'b00}),
    .i_eng_wdata(r_word),
    .o_ram_we   (io_bus.ram_we),
    .o_ram_be   (io_bus.ram_be),
    .o_ram_addr (io_bus.ram_addr),
    .o_ram_wdata(io_bus.ram_wdata),
    .o_grant    (w_grant)
  );

  assign io_bus.busy       = w_busy;
  assign io_bus.done       = r_done;
  assign io_bus.flash_req  = w_flash_req;
  assign io_bus.flash_addr = {r_src[21:2], 2'b00};

endmodule

// File: tb/tb_flash_copy_ctrl.sv
// Bench for flash_copy_ctrl: a latency-randomised flash responder and a word-level
// copy model predict RAM contents, request counts and done/busy timing.
module tb_flash_copy_ctrl;
  import flash_copy_pkg::*;

  localparam int RAM_AW = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  flash_copy_if #(.RAM_AW(RAM_AW)) busIf ();

  flash_copy_ctrl #(
    .RAM_AW(RAM_AW),
    .LEN_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(busIf)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  int          cycleNo      = 0;
  int          reqCount     = 0;
  logic [21:0] reqAddr[$];
  int          reqCycles    = 0;
  int          engWrites    = 0;
  int          lastEngCycle = 0;
  logic [31:0] obsMem [128] = '{default: '0};
  logic [31:0] expMem [128] = '{default: '0};
  logic [31:0] salt         = 32'h0000_A5A5;
  int          fixedLat     = 0;
  bit          flashStuck   = 1'b0;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Observed blockram contents plus flash request and engine write bookkeeping.
  always @(negedge clk) begin
    if (busIf.flash_req) reqCycles++;
    if (busIf.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (busIf.ram_be[b]) obsMem[busIf.ram_addr[8:2]][8*b +: 8] = busIf.ram_wdata[8*b +: 8];
      if (!busIf.cpu_we) begin
        engWrites++;
        lastEngCycle = cycleNo;
      end
    end
  end

  function automatic logic [31:0] flashWord(input logic [31:0] addr);
    return (addr & 32'h003F_FFFF) ^ salt;
  endfunction

  function automatic logic [31:0] srcAddr(input logic [31:0] src, input int i);
    return ((src & ~32'd3) + 32'(4 * i)) & 32'h003F_FFFF;
  endfunction

  function automatic int dstIdx(input logic [31:0] dst, input int i);
    return int'((((dst & ~32'd3) + 32'(4 * i)) & 32'h0000_01FF) >> 2);
  endfunction

  // Flash reader model: busy rises the cycle after a request and stays high for the latency.
  initial begin
    logic [21:0] a;
    int          lat;
    busIf.flash_busy  = 1'b0;
    busIf.flash_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (busIf.flash_req) begin
        a   = busIf.flash_addr;
        lat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 5));
        reqCount++;
        reqAddr.push_back(a);
        @(posedge clk); #1;
        busIf.flash_busy = 1'b1;
        if (flashStuck) begin
          while (flashStuck) begin
            @(posedge clk); #1;
          end
        end else begin
          repeat (lat) begin
            @(posedge clk); #1;
          end
        end
        busIf.flash_rdata = flashWord({10'd0, a});
        busIf.flash_busy  = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [31:0] data);
    busIf.cfg_we    = 1'b1;
    busIf.cfg_sel   = sel;
    busIf.cfg_wdata = data;
    tick();
    busIf.cfg_we    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len);
    cfgWrite(SEL_SRC, src);
    cfgWrite(SEL_DST, dst);
    cfgWrite(SEL_LEN, 32'(len));
    cfgWrite(SEL_CTRL, 32'd1);
    @(negedge clk);
    checkOutput("startBusy", 32'(busIf.busy), 32'(len != 0));
    checkOutput("startReq", 32'(busIf.flash_req), 32'(len != 0));
    checkOutput("startDone", 32'(busIf.done), 32'(len == 0));
    if (len != 0) checkOutput("startAddr", 32'(busIf.flash_addr), srcAddr(src, 0));
  endtask

  task automatic modelCopy(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) expMem[dstIdx(dst, i)] = flashWord(srcAddr(src, i));
  endtask

  task automatic finishCopy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int baseReq, input int baseEng, input int baseReqCyc);
    int n = 0;
    int fallCycle;
    while (busIf.busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    fallCycle = cycleNo;
    checkOutput("copyEnds", 32'(busIf.busy), 32'd0);
    checkOutput("doneSet", 32'(busIf.done), 32'd1);
    checkOutput("doneWithLastWrite", 32'(fallCycle), 32'(lastEngCycle + 1));
    checkOutput("engWrites", 32'(engWrites - baseEng), 32'(len));
    checkOutput("reqPulses", 32'(reqCount - baseReq), 32'(len));
    checkOutput("reqCycles", 32'(reqCycles - baseReqCyc), 32'(len));
    for (int i = 0; i < len; i++)
      if (reqAddr.size() > baseReq + i)
        checkOutput($sformatf("reqAddr%0d", i), 32'(reqAddr[baseReq + i]), srcAddr(src, i));
    modelCopy(src, dst, len);
    for (int i = 0; i < len; i++)
      checkOutput($sformatf("ramWord%0d", i), obsMem[dstIdx(dst, i)], expMem[dstIdx(dst, i)]);
  endtask

  task automatic waitFlashFall();
    int n = 0;
    while (busIf.flash_busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (busIf.flash_busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("flashFallSeen", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] src, dst, cpuData;
    logic [3:0]  cpuBe;
    int          len, bReq, bEng, bCyc;
    logic        expBusy, expErr;

    busIf.cfg_we    = 1'b0;
    busIf.cfg_sel   = '0;
    busIf.cfg_wdata = '0;
    busIf.cpu_we    = 1'b0;
    busIf.cpu_be    = '0;
    busIf.cpu_addr  = '0;
    busIf.cpu_wdata = '0;

    $display("[TB] reset state");
    repeat (3) tick();
    reset = 1'b0;
    busIf.cpu_addr  = 9'h0A4;
    busIf.cpu_wdata = 32'hDEAD_BEEF;
    busIf.cpu_be    = 4'h3;
    @(negedge clk);
    checkOutput("rstBusy", 32'(busIf.busy), 32'd0);
    checkOutput("rstDone", 32'(busIf.done), 32'd0);
    checkOutput("rstError", 32'(busIf.error), 32'd0);
    checkOutput("rstReq", 32'(busIf.flash_req), 32'd0);
    checkOutput("rstAddr", 32'(busIf.flash_addr), 32'd0);
    checkOutput("idleRamWe", 32'(busIf.ram_we), 32'd0);
    checkOutput("idleRamAddr", 32'(busIf.ram_addr), 32'h0A4);
    checkOutput("idleRamData", busIf.ram_wdata, 32'hDEAD_BEEF);
    checkOutput("idleRamBe", 32'(busIf.ram_be), 32'h3);

    $display("[TB] basic three-word copy");
    salt = 32'h0000_A5A5;
    fixedLat = 5;
    bReq = reqCount; bEng = engWrites; bCyc = reqCycles;
    applyStimulus(32'h100, 32'h40, 3);
    finishCopy(32'h100, 32'h40, 3, bReq, bEng, bCyc);
    checkOutput("word40", obsMem[16], 32'h0000_A4A5);

    $display("[TB] zero-length start");
    repeat (3) tick();
    @(negedge clk);
    checkOutput("doneSticky", 32'(busIf.done), 32'd1);
    bReq = reqCount;
    applyStimulus(32'h200, 32'h80, 0);
    repeat (5) tick();
    @(negedge clk);
    checkOutput("zeroNoReq", 32'(reqCount - bReq), 32'd0);
    checkOutput("zeroBusy", 32'(busIf.busy), 32'd0);
    checkOutput("zeroDone", 32'(busIf.done), 32'd1);

    $display("[TB] CPU contention during engine write");
    salt = $urandom;
    fixedLat = 3;
    cpuData = $urandom;
    cpuBe = 4'b0110;
    bReq = reqCount; bEng = engWrites; bCyc = reqCycles;
    applyStimulus(32'h300, 32'h100, 2);
    waitFlashFall();
    tick();
    busIf.cpu_we    = 1'b1;
    busIf.cpu_addr  = 9'h010;
    busIf.cpu_wdata = cpuData;
    busIf.cpu_be    = cpuBe;
    @(negedge clk);
    checkOutput("cpuWe", 32'(busIf.ram_we), 32'd1);
    checkOutput("cpuAddr", 32'(busIf.ram_addr), 32'h010);
    checkOutput("cpuData", busIf.ram_wdata, cpuData);
    checkOutput("cpuBe", 32'(busIf.ram_be), 32'(cpuBe));
    repeat (4) tick();
    checkOutput("noEngDuringCpu", 32'(engWrites - bEng), 32'd0);
    busIf.cpu_we = 1'b0;
    @(negedge clk);
    checkOutput("engWe", 32'(busIf.ram_we), 32'd1);
    checkOutput("engAddr", 32'(busIf.ram_addr), 32'h100);
    checkOutput("engBe", 32'(busIf.ram_be), 32'hF);
    checkOutput("engData", busIf.ram_wdata, flashWord(32'h300));
    for (int b = 0; b < 4; b++)
      if (cpuBe[b]) expMem[4][8*b +: 8] = cpuData[8*b +: 8];
    finishCopy(32'h300, 32'h100, 2, bReq, bEng, bCyc);
    checkOutput("cpuStoreKept", obsMem[4], expMem[4]);

    $display("[TB] destination wrap");
    salt = $urandom;
    fixedLat = 0;
    src = $urandom & 32'h003F_FFFF;
    bReq = reqCount; bEng = engWrites; bCyc = reqCycles;
    applyStimulus(src, 32'h1FC, 2);
    finishCopy(src, 32'h1FC, 2, bReq, bEng, bCyc);
    checkOutput("wrapWord0", obsMem[0], flashWord(srcAddr(src, 1)));

    $display("[TB] randomized copies");
    for (int t = 0; t < 3; t++) begin
      salt = $urandom;
      src  = $urandom;
      dst  = $urandom;
      len  = int'($urandom_range(1, 6));
      bReq = reqCount; bEng = engWrites; bCyc = reqCycles;
      applyStimulus(src, dst, len);
      finishCopy(src, dst, len, bReq, bEng, bCyc);
    end

    $display("[TB] reset during second word");
    salt = $urandom;
    fixedLat = 4;
    bReq = reqCount; bEng = engWrites;
    applyStimulus(32'h40, 32'h180, 3);
    for (int n = 0; n < 100 && reqCount < bReq + 2; n++) @(negedge clk);
    checkOutput("secondReqSeen", 32'(reqCount - bReq), 32'd2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(busIf.busy), 32'd0);
    checkOutput("midRstDone", 32'(busIf.done), 32'd0);
    checkOutput("midRstReq", 32'(busIf.flash_req), 32'd0);
    checkOutput("midRstAddr", 32'(busIf.flash_addr), 32'd0);
    modelCopy(32'h40, 32'h180, 1);
    checkOutput("midRstWord0", obsMem[dstIdx(32'h180, 0)], expMem[dstIdx(32'h180, 0)]);
    checkOutput("midRstWord1", obsMem[dstIdx(32'h180, 1)], expMem[dstIdx(32'h180, 1)]);
    repeat (10) tick();
    checkOutput("midRstWrites", 32'(engWrites - bEng), 32'd1);
    checkOutput("midRstIdle", 32'(busIf.busy), 32'd0);

    $display("[TB] stuck flash reader");
    flashStuck = 1'b1;
    fixedLat = 0;
    applyStimulus(32'h0, 32'h0, 1);
    repeat (1023) tick();
    @(negedge clk);
    checkOutput("stuckLastWait", 32'(busIf.busy), 32'd1);
    tick();
`ifdef FLASH_COPY_TIMEOUT_EN
    expBusy = 1'b0;
    expErr  = 1'b1;
`else
    expBusy = 1'b1;
    expErr  = 1'b0;
`endif
    @(negedge clk);
    checkOutput("stuckBusy", 32'(busIf.busy), 32'(expBusy));
    checkOutput("stuckError", 32'(busIf.error), 32'(expErr));
    checkOutput("stuckDone", 32'(busIf.done), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    flashStuck = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    checkOutput("recoverBusy", 32'(busIf.busy), 32'd0);
    checkOutput("recoverError", 32'(busIf.error), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
